// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Sys_clk cycles per oversample tick (integer division, caller keeps it >= 1).
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running enable generator: one-cycle tick every DIV sys_clk cycles.
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic sys_clk,
    input  logic sreset_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge sys_clk) begin
        if (!sreset_n || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with parity/stop checking, valid/ready output
// register, sticky overrun, all in the sys_clk domain via a baud-tick enable.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 1_000_000,
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter parity_e     PARITY_MODE  = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  sys_clk,
    input  logic                  sreset_n,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned DIV = baud_div(SYS_CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned OSW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

    logic rxd_meta, rxd_s, rxd_d;
    logic fall_pend;
    logic tick;
    logic start_go, load, mid_bit;

    rx_state_e             state, state_nxt;
    logic [OSW-1:0]        os_cnt, os_nxt;
    logic [BCW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic                  perr_acc, perr_nxt;
    logic                  ferr_acc, ferr_nxt;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .sys_clk  (sys_clk),
        .sreset_n (sreset_n),
        .clr      (start_go),
        .tick     (tick)
    );

    // Only a falling edge seen while idle may start a frame, so a line stuck
    // low (break, or a low stop bit) cannot retrigger reception.
    always_ff @(posedge sys_clk) begin
        if (!sreset_n) begin
            rxd_meta  <= 1'b1;
            rxd_s     <= 1'b1;
            rxd_d     <= 1'b1;
            fall_pend <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_d    <= rxd_s;
            if (state == IDLE && rxd_d && !rxd_s) begin
                fall_pend <= 1'b1;
            end else if (start_go || rxd_s) begin
                fall_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sreset_n) begin
            state    <= IDLE;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            state    <= state_nxt;
            os_cnt   <= os_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            perr_acc <= perr_nxt;
            ferr_acc <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        os_nxt    = os_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        perr_nxt  = perr_acc;
        ferr_nxt  = ferr_acc;
        start_go  = 1'b0;
        load      = 1'b0;
        mid_bit   = (os_cnt == OSW'(OVERSAMPLE - 1));
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxd_s && (fall_pend || rxd_d)) begin
                        state_nxt = START;
                        os_nxt    = '0;
                        bit_nxt   = '0;
                        perr_nxt  = 1'b0;
                        ferr_nxt  = 1'b0;
                        start_go  = 1'b1;
                    end
                end
                START: begin
                    if (os_cnt == OSW'(OVERSAMPLE / 2 - 1)) begin
                        os_nxt    = '0;
                        state_nxt = rxd_s ? IDLE : DATA;
                    end else begin
                        os_nxt = os_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        os_nxt    = '0;
                        shreg_nxt = {rxd_s, shreg[DATA_WIDTH-1:1]};
                        if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                            bit_nxt   = '0;
                            state_nxt = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end else begin
                        os_nxt = os_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (mid_bit) begin
                        os_nxt    = '0;
                        perr_nxt  = ((^shreg) ^ rxd_s) != (PARITY_MODE == PAR_ODD);
                        state_nxt = STOP;
                    end else begin
                        os_nxt = os_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (mid_bit) begin
                        os_nxt   = '0;
                        ferr_nxt = ferr_acc | ~rxd_s;
                        if (bit_cnt == BCW'(STOP_BITS - 1)) begin
                            bit_nxt   = '0;
                            load      = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end else begin
                        os_nxt = os_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // A load with no room drops the new word; a same-cycle handshake makes room.
    always_ff @(posedge sys_clk) begin
        if (!sreset_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg;
                parity_err <= perr_acc;
                frame_err  <= ferr_nxt;
                rx_valid   <= 1'b1;
            end else begin
                if (load) begin
                    overrun <= 1'b1;
                end
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three receivers (8N1, 8E1, 8N2) driven by
// bit-level frames, checked against a word-level expectation queue.
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 10_000;
    localparam int unsigned OS     = 16;
    localparam int          BIT    = 160;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       sreset_n;
    logic [2:0] rxd, rdy, valid, perr, ferr, ovr, busy;
    logic [7:0] data [3];

    exp_t       exp_q[$];
    logic [2:0] exp_ovr;
    int         total = 0;
    int         bad   = 0;
    int         hs_cnt [3];
    int         vcyc   [3];
    logic [7:0] last_d [3];
    logic       last_pe [3];
    logic       last_fe [3];

    always #5 clk = ~clk;

    uart_rx_os #(.SYS_CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_WIDTH(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(1)) u_n1 (
        .sys_clk(clk), .sreset_n(sreset_n), .rxd(rxd[0]), .rx_data(data[0]),
        .rx_valid(valid[0]), .rx_ready(rdy[0]), .parity_err(perr[0]),
        .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0]));

    uart_rx_os #(.SYS_CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_WIDTH(8), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1)) u_e1 (
        .sys_clk(clk), .sreset_n(sreset_n), .rxd(rxd[1]), .rx_data(data[1]),
        .rx_valid(valid[1]), .rx_ready(rdy[1]), .parity_err(perr[1]),
        .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1]));

    uart_rx_os #(.SYS_CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_WIDTH(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(2)) u_n2 (
        .sys_clk(clk), .sreset_n(sreset_n), .rxd(rxd[2]), .rx_data(data[2]),
        .rx_valid(valid[2]), .rx_ready(rdy[2]), .parity_err(perr[2]),
        .frame_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Output-register model at word level: a word finding an unaccepted word
    // still waiting (consumer not ready) is lost and overrun becomes expected.
    task automatic model_load(input int ch, input exp_t e);
        if (exp_q.size() != 0 && exp_q[0].ch == 2'(ch) && !rdy[ch])
            exp_ovr[ch] = 1'b1;
        else
            exp_q.push_back(e);
    endtask

    task automatic drive(input int ch, input logic v);
        @(negedge clk);
        rxd[ch] = v;
        repeat (BIT - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int ch, input logic [7:0] d, input bit has_par,
                              input logic pbit, input int nstop, input logic [1:0] stops,
                              input bit model);
        exp_t e;
        int   ones;
        if (model) begin
            ones = $countones(d) + int'(pbit);
            e.ch = 2'(ch);
            e.d  = d;
            e.pe = has_par && ((ones % 2) != 0);
            e.fe = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
            model_load(ch, e);
        end
        drive(ch, 1'b0);
        for (int i = 0; i < 8; i++) drive(ch, d[i]);
        if (has_par) drive(ch, pbit);
        for (int i = 0; i < nstop; i++) drive(ch, stops[i]);
    endtask

    task automatic drained(input string name);
        idle(20);
        check(name, exp_q.size(), 0);
    endtask

    // Every cycle a word is presented it must match the oldest expected word.
    always @(negedge clk) begin
        #1;
        for (int c = 0; c < 3; c++) begin
            if (valid[c]) begin
                vcyc[c]++;
                total++;
                if (exp_q.size() == 0 || exp_q[0].ch != 2'(c)) begin
                    bad++;
                    if (bad < 20)
                        $display("FAIL unexpected_word ch%0d: got data=0x%0h presented, required no word",
                                 c, data[c]);
                end else if ({data[c], perr[c], ferr[c]} !== {exp_q[0].d, exp_q[0].pe, exp_q[0].fe}) begin
                    bad++;
                    if (bad < 20)
                        $display("FAIL word ch%0d: got data=0x%0h pe=%0b fe=%0b, required data=0x%0h pe=%0b fe=%0b",
                                 c, data[c], perr[c], ferr[c], exp_q[0].d, exp_q[0].pe, exp_q[0].fe);
                end
                if (rdy[c]) begin
                    hs_cnt[c]++;
                    last_d[c]  = data[c];
                    last_pe[c] = perr[c];
                    last_fe[c] = ferr[c];
                    if (exp_q.size() != 0 && exp_q[0].ch == 2'(c)) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int hs0, v0;
        for (int c = 0; c < 3; c++) begin
            hs_cnt[c] = 0;
            vcyc[c]   = 0;
        end
        exp_ovr  = '0;
        sreset_n = 1'b0;
        rxd      = '1;
        rdy      = '1;
        idle(5);
        for (int c = 0; c < 3; c++)
            check($sformatf("reset_outputs_ch%0d", c),
                  {data[c], valid[c], perr[c], ferr[c], ovr[c], busy[c]}, 0);
        sreset_n = 1'b1;
        idle(50);

        // 8N1 clean frame
        hs0 = hs_cnt[0];
        v0  = vcyc[0];
        send_frame(0, 8'hA5, 0, 1'b0, 1, 2'b11, 1);
        drained("t1_drained");
        check("t1_handshakes", hs_cnt[0] - hs0, 1);
        check("t1_valid_cycles", vcyc[0] - v0, 1);
        check("t1_data", last_d[0], 8'hA5);
        check("t1_flags", {last_pe[0], last_fe[0]}, 0);

        // 8E1: wrong then right parity bit for 0x07 (three ones -> parity bit 1)
        send_frame(1, 8'h07, 1, 1'b0, 1, 2'b11, 1);
        drained("t2a_drained");
        check("t2a_data", last_d[1], 8'h07);
        check("t2a_parity_err", last_pe[1], 1);
        send_frame(1, 8'h07, 1, 1'b1, 1, 2'b11, 1);
        drained("t2b_drained");
        check("t2b_parity_err", last_pe[1], 0);

        // 8N2: low second stop bit, then two back-to-back clean frames
        hs0 = hs_cnt[2];
        send_frame(2, 8'h96, 0, 1'b0, 2, 2'b01, 1);
        drive(2, 1'b1);
        check("t3a_data", last_d[2], 8'h96);
        check("t3a_frame_err", last_fe[2], 1);
        send_frame(2, 8'h5A, 0, 1'b0, 2, 2'b11, 1);
        send_frame(2, 8'h3C, 0, 1'b0, 2, 2'b11, 1);
        drained("t3_drained");
        check("t3_handshakes", hs_cnt[2] - hs0, 3);
        check("t3b_data", last_d[2], 8'h3C);
        check("t3b_frame_err", last_fe[2], 0);

        // 60-clk glitch is rejected at mid-start
        hs0 = hs_cnt[0];
        @(negedge clk);
        rxd[0] = 1'b0;
        idle(60);
        check("t4_busy_during_glitch", busy[0], 1);
        rxd[0] = 1'b1;
        idle(200);
        check("t4_busy_after_glitch", busy[0], 0);
        check("t4_no_word", hs_cnt[0] - hs0, 0);
        send_frame(0, 8'h55, 0, 1'b0, 1, 2'b11, 1);
        drained("t4_drained");
        check("t4_data", last_d[0], 8'h55);

        // overrun with consumer stalled
        rdy[0] = 1'b0;
        send_frame(0, 8'h11, 0, 1'b0, 1, 2'b11, 1);
        idle(2 * BIT);
        send_frame(0, 8'h22, 0, 1'b0, 1, 2'b11, 1);
        idle(2 * BIT);
        check("t5_held_valid", valid[0], 1);
        check("t5_held_data", data[0], 8'h11);
        check("t5_overrun", ovr[0], 1);
        check("t5_overrun_model", ovr[0], exp_ovr[0]);
        rdy[0] = 1'b1;
        idle(5);
        check("t5_valid_cleared", valid[0], 0);
        check("t5_handshake_data", last_d[0], 8'h11);
        check("t5_overrun_sticky", ovr[0], 1);
        drained("t5_drained");

        // reset mid-DATA abandons the frame
        hs0 = hs_cnt[0];
        fork
            send_frame(0, 8'hFF, 0, 1'b0, 1, 2'b11, 0);
            begin
                idle(560);
                check("t6_busy_before_reset", busy[0], 1);
                sreset_n = 1'b0;
                @(negedge clk);
                check("t6_outputs_reset",
                      {data[0], valid[0], perr[0], ferr[0], ovr[0], busy[0]}, 0);
                sreset_n = 1'b1;
                exp_ovr  = '0;
                exp_q.delete();
            end
        join
        idle(BIT);
        check("t6_no_word", hs_cnt[0] - hs0, 0);
        send_frame(0, 8'h81, 0, 1'b0, 1, 2'b11, 1);
        drained("t6_drained");
        check("t6_data", last_d[0], 8'h81);
        check("t6_overrun_clear", ovr[0], exp_ovr[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
